mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle main controller for the MIPS-subset core. It sequences fetch, decode, execute, memory and write-back, and drives every datapath select and write enable. This includes the GRF write-address select (GRF_A3_sel) and the GRF write-data select (GRF_WD_sel). It also handshakes with the instruction and data memories through ready signals, so that variable-latency memory stalls the FSM.

Parameters:
- STATE_W, 3, width of the state code exported for debug.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces state to S_FETCH immediately.
- opcode  in  6  IR[31:26], taken from the IR register (stable after ir_we).
- funct  in  6  IR[5:0].
- zero  in  1  ALU equal flag, valid in S_EXEC.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data memory access completes this cycle.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- grf_we  out  1  register file write enable.
- dm_we  out  1  data memory write enable.
- npc_sel  out  2  0=PC+4, 1=branch target, 2=J-immediate, 3=GRF rs (jr).
- GRF_A3_sel  out  2  0=rt, 1=rd, 2=$31.
- GRF_WD_sel  out  2  0=ALU result register, 1=DM data register, 2=PC (already PC+4).
- alu_op  out  2  0=add, 1=sub, 2=or, 3=lui (imm<<16).
- alusrc  out  1  0=GRF rt, 1=extended immediate.
- ext_op  out  1  0=zero-extend, 1=sign-extend.
- illegal  out  1  one-cycle pulse in S_DECODE for an unsupported opcode or funct.
- state  out  STATE_W  current state code, for debug.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.

Behaviour:
- States and codes: S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4. Codes 5-7 are unreachable and recover to S_FETCH.
- Outputs are combinational from state, opcode, funct and the ready inputs.
- Any output not driven in a state is 0.
- While reset is high, pc_we, ir_we, grf_we, dm_we, illegal and instr_done are forced to 0, and state=0.
- Supported instructions:
  - R-type (opcode 000000): addu (funct 100001), subu (100011), jr (001000).
  - I/J-type opcodes: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
- S_FETCH:
  - imem_ready=0: hold, all enables 0.
  - imem_ready=1: ir_we=1, pc_we=1, npc_sel=0; go to S_DECODE.
- S_DECODE:
  - j: pc_we=1, npc_sel=2, instr_done=1; go to S_FETCH.
  - jal: pc_we=1, npc_sel=2, grf_we=1, GRF_A3_sel=2, GRF_WD_sel=2, instr_done=1; go to S_FETCH. The GRF captures the pre-jump PC on the same edge.
  - jr: pc_we=1, npc_sel=3, instr_done=1; go to S_FETCH.
  - Unsupported opcode or funct: illegal=1, instr_done=1; go to S_FETCH. The instruction is treated as a NOP.
  - All others: go to S_EXEC.
- S_EXEC:
  - addu: alu_op=0, alusrc=0. subu: alu_op=1, alusrc=0.
  - ori: alu_op=2, alusrc=1, ext_op=0. lui: alu_op=3, alusrc=1.
  - lw and sw: alu_op=0, alusrc=1, ext_op=1.
  - beq: alu_op=1, alusrc=0, ext_op=1, npc_sel=1, pc_we=zero, instr_done=1; go to S_FETCH.
  - lw and sw go to S_MEM; addu, subu, ori and lui go to S_WB.
- S_MEM:
  - sw: dm_we=1, held every cycle until dmem_ready=1. On that cycle instr_done=1; go to S_FETCH.
  - lw: wait for dmem_ready=1, then go to S_WB. dm_we stays 0.
- S_WB: grf_we=1, instr_done=1; go to S_FETCH.
  - R-type: GRF_A3_sel=1, GRF_WD_sel=0.
  - ori and lui: GRF_A3_sel=0, GRF_WD_sel=0.
  - lw: GRF_A3_sel=0, GRF_WD_sel=1.
- Instruction latency with zero wait states:
  - j, jal, jr: 2 cycles.
  - beq: 3 cycles.
  - R-type, ori, lui, sw: 4 cycles.
  - lw: 5 cycles.
- Reset asserted mid-instruction aborts it: no further enables, and fetch restarts when reset is released.
- A ready signal asserted in a state that does not consume it is ignored.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct constants;
  - state codes;
  - npc_sel, GRF_A3_sel, GRF_WD_sel and alu_op encodings.
- Sub-module mc_decode (combinational): maps opcode and funct to a one-hot instruction class plus an illegal flag. mc_ctrl owns the FSM and the output decode.

Test Plan:
- addu (funct 100001), ready signals tied high → 4 cycles. The S_WB cycle shows grf_we=1, GRF_A3_sel=1, GRF_WD_sel=0, and instr_done pulses once.
- lw with dmem_ready low for 3 cycles → state stays 3 for 4 cycles, then S_WB with GRF_A3_sel=0 and GRF_WD_sel=1. Total 8 cycles.
- sw with dmem_ready low for 2 cycles → dm_we=1 on exactly 3 consecutive cycles, and grf_we is never asserted.
- beq with zero=1, then with zero=0 → pc_we=1 and npc_sel=1 in S_EXEC for the first; pc_we=0 for the second. Both return to S_FETCH after 3 cycles.
- jal → in S_DECODE, grf_we=1, GRF_A3_sel=2, GRF_WD_sel=2, pc_we=1, npc_sel=2, all in the same cycle.
- Opcode 111111 → illegal pulses once in S_DECODE. Separately, assert reset in S_MEM during an sw → dm_we drops to 0 immediately, state=0, and fetch resumes after reset is released.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the multi-cycle MIPS-subset control path.
// Holds opcode/funct codes, FSM state codes, datapath select encodings and the
// one-hot instruction class produced by mc_decode.
package mips_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // FSM state codes; 5-7 are unreachable
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  // npc_sel encodings
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JIMM   = 2'd2;
  localparam logic [1:0] NPC_RS     = 2'd3;

  // GRF write-address select
  localparam logic [1:0] A3_RT  = 2'd0;
  localparam logic [1:0] A3_RD  = 2'd1;
  localparam logic [1:0] A3_RA  = 2'd2;

  // GRF write-data select
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  // ALU operation
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;

  // One-hot instruction class; all-zero when the instruction is unsupported
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
  } instr_cls_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
// Ports:
//   opcode_i  - IR[31:26]
//   funct_i   - IR[5:0], only meaningful for R-type
//   cls_o     - one-hot instruction class (all zero when unsupported)
//   illegal_o - high for an unsupported opcode, or R-type with unsupported funct
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output instr_cls_t cls_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o     = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: cls_o.addu = 1'b1;
          FN_SUBU: cls_o.subu = 1'b1;
          FN_JR:   cls_o.jr   = 1'b1;
          default: illegal_o  = 1'b1;
        endcase
      end
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_LUI:  cls_o.lui = 1'b1;
      OP_J:    cls_o.j   = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller (fetch/decode/exec/mem/wb).
// Drives all datapath selects and write enables; stalls on imem_ready in
// S_FETCH and on dmem_ready in S_MEM.
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   opcode, funct          - fields of the IR register
//   zero                   - ALU equal flag (used by beq in S_EXEC)
//   imem_ready, dmem_ready - memory handshakes
//   pc_we, ir_we, grf_we, dm_we - write enables
//   npc_sel, GRF_A3_sel, GRF_WD_sel, alu_op, alusrc, ext_op - datapath selects
//   illegal                - pulse in S_DECODE for an unsupported instruction
//   state                  - current state code (debug)
//   instr_done             - pulse in the last cycle of each instruction
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned STATE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               pc_we,
  output logic               ir_we,
  output logic               grf_we,
  output logic               dm_we,
  output logic [1:0]         npc_sel,
  output logic [1:0]         GRF_A3_sel,
  output logic [1:0]         GRF_WD_sel,
  output logic [1:0]         alu_op,
  output logic               alusrc,
  output logic               ext_op,
  output logic               illegal,
  output logic [STATE_W-1:0] state,
  output logic               instr_done
);

  state_e     state_q, state_d;
  instr_cls_t cls;
  logic       dec_illegal;

  // Ungated enables; reset masks them below so nothing is written while the
  // FSM is held in S_FETCH by reset.
  logic pc_we_c, ir_we_c, grf_we_c, dm_we_c, illegal_c, done_c;

  mc_decode u_decode (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .cls_o     (cls),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_we_c    = 1'b0;
    ir_we_c    = 1'b0;
    grf_we_c   = 1'b0;
    dm_we_c    = 1'b0;
    illegal_c  = 1'b0;
    done_c     = 1'b0;
    npc_sel    = NPC_PC4;
    GRF_A3_sel = A3_RT;
    GRF_WD_sel = WD_ALU;
    alu_op     = ALU_ADD;
    alusrc     = 1'b0;
    ext_op     = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          npc_sel = NPC_PC4;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (dec_illegal) begin
          // Unsupported instruction retires as a NOP
          illegal_c = 1'b1;
          done_c    = 1'b1;
          state_d   = S_FETCH;
        end else if (cls.j) begin
          pc_we_c = 1'b1;
          npc_sel = NPC_JIMM;
          done_c  = 1'b1;
          state_d = S_FETCH;
        end else if (cls.jal) begin
          // PC already holds PC+4, so the link value is captured on this edge
          pc_we_c    = 1'b1;
          npc_sel    = NPC_JIMM;
          grf_we_c   = 1'b1;
          GRF_A3_sel = A3_RA;
          GRF_WD_sel = WD_PC;
          done_c     = 1'b1;
          state_d    = S_FETCH;
        end else if (cls.jr) begin
          pc_we_c = 1'b1;
          npc_sel = NPC_RS;
          done_c  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        if (cls.addu) begin
          alu_op  = ALU_ADD;
          state_d = S_WB;
        end else if (cls.subu) begin
          alu_op  = ALU_SUB;
          state_d = S_WB;
        end else if (cls.ori) begin
          alu_op  = ALU_OR;
          alusrc  = 1'b1;
          state_d = S_WB;
        end else if (cls.lui) begin
          alu_op  = ALU_LUI;
          alusrc  = 1'b1;
          state_d = S_WB;
        end else if (cls.lw || cls.sw) begin
          alu_op  = ALU_ADD;
          alusrc  = 1'b1;
          ext_op  = 1'b1;
          state_d = S_MEM;
        end else if (cls.beq) begin
          alu_op  = ALU_SUB;
          ext_op  = 1'b1;
          npc_sel = NPC_BRANCH;
          pc_we_c = zero;
          done_c  = 1'b1;
        end
      end

      S_MEM: begin
        if (cls.sw) begin
          // Write strobe held until the memory accepts it
          dm_we_c = 1'b1;
          if (dmem_ready) begin
            done_c  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (cls.lw) begin
          if (dmem_ready) begin
            state_d = S_WB;
          end
        end else begin
          state_d = S_FETCH;
        end
      end

      S_WB: begin
        state_d = S_FETCH;
        if (cls.addu || cls.subu) begin
          grf_we_c   = 1'b1;
          GRF_A3_sel = A3_RD;
          GRF_WD_sel = WD_ALU;
          done_c     = 1'b1;
        end else if (cls.ori || cls.lui) begin
          grf_we_c   = 1'b1;
          GRF_A3_sel = A3_RT;
          GRF_WD_sel = WD_ALU;
          done_c     = 1'b1;
        end else if (cls.lw) begin
          grf_we_c   = 1'b1;
          GRF_A3_sel = A3_RT;
          GRF_WD_sel = WD_DM;
          done_c     = 1'b1;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign pc_we      = pc_we_c   & ~reset;
  assign ir_we      = ir_we_c   & ~reset;
  assign grf_we     = grf_we_c  & ~reset;
  assign dm_we      = dm_we_c   & ~reset;
  assign illegal    = illegal_c & ~reset;
  assign instr_done = done_c    & ~reset;
  assign state      = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench for mc_ctrl. Each instruction is
// expanded into its expected cycle-by-cycle phase script, and every cycle the
// full output vector is compared against the expected vector for that phase.
module tb_mc_ctrl;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_JR   = 6'b001000;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_LUI = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3;
  localparam int P_MEMW = 4, P_MEMD = 5, P_WB = 6;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       grf_we;
    logic       dm_we;
    logic [1:0] npc_sel;
    logic [1:0] a3;
    logic [1:0] wd;
    logic [1:0] alu_op;
    logic       alusrc;
    logic       ext_op;
    logic       illegal;
    logic [2:0] state;
    logic       instr_done;
  } out_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, imem_ready, dmem_ready;
  logic       pc_we, ir_we, grf_we, dm_we, alusrc, ext_op, illegal, instr_done;
  logic [1:0] npc_sel, grf_a3_sel, grf_wd_sel, alu_op;
  logic [2:0] state;
  out_t       dut_out;

  int errors = 0;
  int checks = 0;

  // Per-instruction observations
  int   cyc, done_cnt, done_cyc, dm_cnt, grf_cnt, ill_cnt, mem_cnt;
  out_t done_out, exec_out;

  always #5 clk = ~clk;

  mc_ctrl #(.STATE_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .grf_we     (grf_we),
    .dm_we      (dm_we),
    .npc_sel    (npc_sel),
    .GRF_A3_sel (grf_a3_sel),
    .GRF_WD_sel (grf_wd_sel),
    .alu_op     (alu_op),
    .alusrc     (alusrc),
    .ext_op     (ext_op),
    .illegal    (illegal),
    .state      (state),
    .instr_done (instr_done)
  );

  assign dut_out = {pc_we, ir_we, grf_we, dm_we, npc_sel, grf_a3_sel, grf_wd_sel, alu_op,
                    alusrc, ext_op, illegal, state, instr_done};

  // Expected outputs for one phase of an instruction, straight from the rule table
  function automatic out_t model(input int kind, input int ph, input logic z);
    out_t o;
    o = '0;
    case (ph)
      P_FETCH: begin
        o.ir_we = 1'b1;
        o.pc_we = 1'b1;
      end
      P_DEC: begin
        o.state = 3'd1;
        if (kind == K_J) begin
          o.pc_we = 1'b1; o.npc_sel = 2'd2; o.instr_done = 1'b1;
        end else if (kind == K_JAL) begin
          o.pc_we = 1'b1; o.npc_sel = 2'd2; o.grf_we = 1'b1;
          o.a3 = 2'd2; o.wd = 2'd2; o.instr_done = 1'b1;
        end else if (kind == K_JR) begin
          o.pc_we = 1'b1; o.npc_sel = 2'd3; o.instr_done = 1'b1;
        end else if (kind == K_ILL) begin
          o.illegal = 1'b1; o.instr_done = 1'b1;
        end
      end
      P_EXEC: begin
        o.state = 3'd2;
        case (kind)
          K_ADDU: o.alu_op = 2'd0;
          K_SUBU: o.alu_op = 2'd1;
          K_ORI:  begin o.alu_op = 2'd2; o.alusrc = 1'b1; end
          K_LUI:  begin o.alu_op = 2'd3; o.alusrc = 1'b1; end
          K_LW, K_SW: begin o.alu_op = 2'd0; o.alusrc = 1'b1; o.ext_op = 1'b1; end
          K_BEQ: begin
            o.alu_op = 2'd1; o.ext_op = 1'b1; o.npc_sel = 2'd1;
            o.pc_we = z; o.instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      P_MEMW, P_MEMD: begin
        o.state = 3'd3;
        if (kind == K_SW) begin
          o.dm_we = 1'b1;
          o.instr_done = (ph == P_MEMD);
        end
      end
      P_WB: begin
        o.state = 3'd4;
        o.grf_we = 1'b1;
        o.instr_done = 1'b1;
        if (kind == K_ADDU || kind == K_SUBU) o.a3 = 2'd1;
        if (kind == K_LW) o.wd = 2'd1;
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cmp_cycle(input out_t expv, input int kind, input int ph);
    checks++;
    if (dut_out !== expv) begin
      errors++;
      $display("FAIL cycle kind=%0d phase=%0d: got %b expected %b at %0t",
               kind, ph, dut_out, expv, $time);
    end
    cyc++;
    if (dut_out.instr_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_out = dut_out;
    end
    if (dut_out.dm_we)      dm_cnt++;
    if (dut_out.grf_we)     grf_cnt++;
    if (dut_out.illegal)    ill_cnt++;
    if (dut_out.state == 3) mem_cnt++;
    if (dut_out.state == 2) exec_out = dut_out;
  endtask

  task automatic clear_stats();
    cyc = 0; done_cnt = 0; done_cyc = 0; dm_cnt = 0; grf_cnt = 0;
    ill_cnt = 0; mem_cnt = 0; done_out = '0; exec_out = '0;
  endtask

  // One cycle: entered just after a rising edge, compares on the falling edge
  task automatic step(input int kind, input int ph, input int zmode);
    imem_ready = (ph == P_IDLE)  ? 1'b0 : (ph == P_FETCH) ? 1'b1 : 1'($urandom);
    dmem_ready = (ph == P_MEMW)  ? 1'b0 : (ph == P_MEMD)  ? 1'b1 : 1'($urandom);
    zero       = (zmode == 2) ? 1'($urandom) : 1'(zmode);
    @(negedge clk);
    cmp_cycle(model(kind, ph, zero), kind, ph);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input int zmode);
    int ph[$];
    for (int i = 0; i < fw; i++) ph.push_back(P_IDLE);
    ph.push_back(P_FETCH);
    ph.push_back(P_DEC);
    if (!(kind inside {K_J, K_JAL, K_JR, K_ILL})) begin
      ph.push_back(P_EXEC);
      if (kind == K_LW || kind == K_SW) begin
        for (int i = 0; i < mw; i++) ph.push_back(P_MEMW);
        ph.push_back(P_MEMD);
      end
      if (kind inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW}) ph.push_back(P_WB);
    end
    opcode = op;
    funct  = fn;
    clear_stats();
    foreach (ph[i]) step(kind, ph[i], zmode);
  endtask

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {OP_R, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_J, OP_JAL};
  endfunction

  logic [5:0] op_tab [10];
  logic [5:0] fn_tab [10];

  initial begin
    op_tab = '{OP_R, OP_R, OP_R, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_J, OP_JAL};
    fn_tab = '{F_ADDU, F_SUBU, F_JR, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

    // Reset: enables stay low even with imem_ready high
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    @(posedge clk); #1;
    clear_stats();
    @(negedge clk);
    cmp_cycle(model(K_ILL, P_IDLE, 1'b0), K_ILL, P_IDLE);
    chk("reset_pc_we", int'(pc_we), 0);
    chk("reset_ir_we", int'(ir_we), 0);
    chk("reset_state", int'(state), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // addu, zero wait states
    run_instr(K_ADDU, OP_R, F_ADDU, 0, 0, 2);
    chk("addu_latency", done_cyc, 4);
    chk("addu_done_cnt", done_cnt, 1);
    chk("addu_wb_grf_we", int'(done_out.grf_we), 1);
    chk("addu_wb_a3", int'(done_out.a3), 1);
    chk("addu_wb_wd", int'(done_out.wd), 0);

    // lw with 3 memory wait cycles
    run_instr(K_LW, OP_LW, 6'd0, 0, 3, 2);
    chk("lw_latency", done_cyc, 8);
    chk("lw_mem_cycles", mem_cnt, 4);
    chk("lw_wb_a3", int'(done_out.a3), 0);
    chk("lw_wb_wd", int'(done_out.wd), 1);

    // sw with 2 memory wait cycles
    run_instr(K_SW, OP_SW, 6'd0, 0, 2, 2);
    chk("sw_dm_we_cycles", dm_cnt, 3);
    chk("sw_grf_we_cycles", grf_cnt, 0);
    chk("sw_latency", done_cyc, 6);

    // beq taken / not taken
    run_instr(K_BEQ, OP_BEQ, 6'd0, 0, 0, 1);
    chk("beq_t_pc_we", int'(exec_out.pc_we), 1);
    chk("beq_t_npc", int'(exec_out.npc_sel), 1);
    chk("beq_t_latency", done_cyc, 3);
    run_instr(K_BEQ, OP_BEQ, 6'd0, 0, 0, 0);
    chk("beq_nt_pc_we", int'(exec_out.pc_we), 0);
    chk("beq_nt_latency", done_cyc, 3);

    // jal: link and jump in the same decode cycle
    run_instr(K_JAL, OP_JAL, 6'd0, 0, 0, 2);
    chk("jal_latency", done_cyc, 2);
    chk("jal_grf_we", int'(done_out.grf_we), 1);
    chk("jal_a3", int'(done_out.a3), 2);
    chk("jal_wd", int'(done_out.wd), 2);
    chk("jal_pc_we", int'(done_out.pc_we), 1);
    chk("jal_npc", int'(done_out.npc_sel), 2);

    // Unsupported opcode
    run_instr(K_ILL, 6'b111111, 6'd0, 0, 0, 2);
    chk("ill_pulses", ill_cnt, 1);
    chk("ill_latency", done_cyc, 2);

    // Reset asserted while an sw is stalled in S_MEM
    opcode = OP_SW; funct = '0;
    clear_stats();
    step(K_SW, P_FETCH, 2);
    step(K_SW, P_DEC, 2);
    step(K_SW, P_EXEC, 2);
    step(K_SW, P_MEMW, 2);
    dmem_ready = 1'b0; imem_ready = 1'b1;
    #1;
    chk("abort_pre_dm_we", int'(dm_we), 1);
    chk("abort_pre_state", int'(state), 3);
    reset = 1'b1;
    #1;
    chk("abort_dm_we", int'(dm_we), 0);
    chk("abort_state", int'(state), 0);
    chk("abort_pc_we", int'(pc_we), 0);
    @(negedge clk);
    cmp_cycle(model(K_SW, P_IDLE, 1'b0), K_SW, P_IDLE);
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(K_ADDU, OP_R, F_ADDU, 0, 0, 2);
    chk("post_reset_latency", done_cyc, 4);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      int         r, kind;
      logic [5:0] op, fn;
      r = int'($urandom_range(0, 11));
      if (r < 10) begin
        kind = r;
        op   = op_tab[r];
        fn   = (op == OP_R) ? fn_tab[r] : 6'($urandom);
      end else if (r == 10) begin
        kind = K_ILL;
        op   = 6'($urandom);
        while (legal_op(op)) op = 6'($urandom);
        fn   = 6'($urandom);
      end else begin
        kind = K_ILL;
        op   = OP_R;
        fn   = 6'($urandom);
        while (fn inside {F_ADDU, F_SUBU, F_JR}) fn = 6'($urandom);
      end
      run_instr(kind, op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 2);
      if (done_cnt != 1) chk("rand_done_once", done_cnt, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
